// File: rtl/writeback_unit.sv
// Register-file write-port producer: merges ALU results and FIFO-buffered load
// responses, and tracks outstanding loads. Optional WB_BYPASS_EN adds decode forwarding.
module writeback_unit #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_stall,
  input  logic        ld_issue,
  input  logic [4:0]  ld_issue_rd,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic [4:0]  a3,
  output logic        we3,
  output logic [31:0] wd3,
  output logic [31:0] pending
`ifdef WB_BYPASS_EN
  ,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [31:0] rd1_in,
  input  logic [31:0] rd2_in,
  output logic [31:0] fwd1,
  output logic [31:0] fwd2
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Handshake: a response is accepted on any edge where ld_valid && ld_ready;
  // ld_ready depends only on the registered count. alu_stall tells upstream
  // to hold alu_* stable; the write is accepted on the first edge it is low.
  logic [4:0]    fifo_rd   [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, push, pop, sel_alu;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;
  logic [31:0]   pending_nxt;

  assign full      = (count == FULL_CNT);
  assign ld_ready  = !full;
  assign push      = ld_valid && ld_ready;
  // Pop decision uses the registered count, so a just-pushed entry is never popped the same cycle.
  assign pop       = full || (!alu_valid && (count != '0));
  assign sel_alu   = !full && alu_valid;
  assign alu_stall = full && alu_valid;
  assign head_rd   = fifo_rd[rd_ptr];
  assign head_data = fifo_data[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= ld_rd;
      fifo_data[wr_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Set is applied after clear so a same-cycle re-issue keeps the bit.
  always_comb begin
    pending_nxt = pending;
    if (pop) pending_nxt[head_rd] = 1'b0;
    if (ld_issue && (ld_issue_rd != 5'd0)) pending_nxt[ld_issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a3      <= '0;
      we3     <= 1'b0;
      wd3     <= '0;
      pending <= '0;
    end else begin
      pending <= pending_nxt;
      if (pop) begin
        a3  <= head_rd;
        wd3 <= head_data;
        we3 <= (head_rd != 5'd0);
      end else if (sel_alu) begin
        a3  <= alu_rd;
        wd3 <= alu_data;
        we3 <= (alu_rd != 5'd0);
      end else begin
        we3 <= 1'b0;
      end
    end
  end

`ifdef WB_BYPASS_EN
  assign fwd1 = (we3 && (a3 == ra1) && (ra1 != 5'd0)) ? wd3 : rd1_in;
  assign fwd2 = (we3 && (a3 == ra2) && (ra2 != 5'd0)) ? wd3 : rd2_in;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit (default DEPTH=4).
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        alu_stall;
  logic        ld_issue = 1'b0;
  logic [4:0]  ld_issue_rd = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [4:0]  ld_rd = '0;
  logic [31:0] ld_data = '0;
  logic [4:0]  a3;
  logic        we3;
  logic [31:0] wd3;
  logic [31:0] pending;
`ifdef WB_BYPASS_EN
  logic [4:0]  ra1 = '0, ra2 = '0;
  logic [31:0] rd1_in = '0, rd2_in = '0;
  logic [31:0] fwd1, fwd2;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic reissue_ok = 1'b0;

  writeback_unit dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .a3(a3), .we3(we3), .wd3(wd3), .pending(pending)
`ifdef WB_BYPASS_EN
    , .ra1(ra1), .ra2(ra2), .rd1_in(rd1_in), .rd2_in(rd2_in), .fwd1(fwd1), .fwd2(fwd2)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // Decode contract: no re-issue to a pending register, no ALU write to a pending register.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(ld_issue && ld_issue_rd != 5'd0 && pending[ld_issue_rd] && !reissue_ok))
        else $error("hazard: ld_issue to pending x%0d", ld_issue_rd);
      assert (!(alu_valid && !alu_stall && alu_rd != 5'd0 && pending[alu_rd]))
        else $error("hazard: ALU write to pending x%0d", alu_rd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    rst = 1'b1;
    #3;
    check_eq("rst_we3", 32'(we3), 32'd0);
    check_eq("rst_a3", 32'(a3), 32'd0);
    check_eq("rst_wd3", wd3, 32'd0);
    check_eq("rst_pending", pending, 32'd0);
    check_eq("rst_ld_ready", 32'(ld_ready), 32'd1);
    check_eq("rst_alu_stall", 32'(alu_stall), 32'd0);
    tick();
    rst = 1'b0;

    // 1: single ALU write
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 1'b0;
    check_eq("t1_we3", 32'(we3), 32'd1);
    check_eq("t1_a3", 32'(a3), 32'd5);
    check_eq("t1_wd3", wd3, 32'hDEADBEEF);
    tick();
    check_eq("t1_we3_low", 32'(we3), 32'd0);

    // 2: one load, pending tracking and 2-cycle write latency
    ld_issue = 1'b1; ld_issue_rd = 5'd7;
    tick();
    ld_issue = 1'b0;
    check_eq("t2_pend_set", pending, 32'h0000_0080);
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h1234;
    #1 check_eq("t2_ld_ready", 32'(ld_ready), 32'd1);
    tick();
    ld_valid = 1'b0;
    check_eq("t2_no_fallthru", 32'(we3), 32'd0);
    check_eq("t2_pend_hold", pending, 32'h0000_0080);
    tick();
    check_eq("t2_we3", 32'(we3), 32'd1);
    check_eq("t2_a3", 32'(a3), 32'd7);
    check_eq("t2_wd3", wd3, 32'h1234);
    check_eq("t2_pend_clr", pending, 32'd0);
    tick();
    check_eq("t2_we3_low", 32'(we3), 32'd0);

    // 3: fill FIFO behind an ALU stream, then drain in order
    for (int i = 1; i <= 4; i++) begin
      ld_issue = 1'b1; ld_issue_rd = 5'(i);
      tick();
    end
    ld_issue = 1'b0;
    check_eq("t3_pend", pending, 32'h0000_001E);
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hCAFE0010;
    for (int i = 1; i <= 4; i++) begin
      ld_valid = 1'b1; ld_rd = 5'(i); ld_data = 32'h100 + 32'(i);
      tick();
      check_eq("t3_alu_wr", 32'(a3), 32'd10);
    end
    ld_valid = 1'b0;
    check_eq("t3_full_ready", 32'(ld_ready), 32'd0);
    check_eq("t3_full_stall", 32'(alu_stall), 32'd1);
    tick();
    check_eq("t3_pop1_a3", 32'(a3), 32'd1);
    check_eq("t3_pop1_wd3", wd3, 32'h101);
    check_eq("t3_pop1_pend", pending, 32'h0000_001C);
    check_eq("t3_ready_back", 32'(ld_ready), 32'd1);
    check_eq("t3_stall_off", 32'(alu_stall), 32'd0);
    tick();
    check_eq("t3_alu_a3", 32'(a3), 32'd10);
    check_eq("t3_alu_wd3", wd3, 32'hCAFE0010);
    check_eq("t3_alu_we3", 32'(we3), 32'd1);
    alu_valid = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      tick();
      check_eq("t3_drain_a3", 32'(a3), 32'(i));
      check_eq("t3_drain_wd3", wd3, 32'h100 + 32'(i));
      check_eq("t3_drain_we3", 32'(we3), 32'd1);
    end
    check_eq("t3_pend_empty", pending, 32'd0);
    tick();
    check_eq("t3_idle_we3", 32'(we3), 32'd0);

    // 4: writes to x0 are suppressed
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
    tick();
    alu_valid = 1'b0;
    check_eq("t4_alu_x0", 32'(we3), 32'd0);
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h55;
    tick();
    ld_valid = 1'b0;
    check_eq("t4_push_x0", 32'(we3), 32'd0);
    tick();
    check_eq("t4_pop_x0", 32'(we3), 32'd0);
    tick();
    check_eq("t4_after_x0", 32'(we3), 32'd0);
    check_eq("t4_pend", pending, 32'd0);
    check_eq("t4_ready", 32'(ld_ready), 32'd1);

    // 5: same-cycle retire and re-issue of x9, then reset mid-burst
    ld_issue = 1'b1; ld_issue_rd = 5'd9;
    tick();
    ld_issue = 1'b0;
    check_eq("t5_pend_set", pending, 32'h0000_0200);
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99;
    tick();
    ld_valid = 1'b0;
    ld_issue = 1'b1; ld_issue_rd = 5'd9; reissue_ok = 1'b1;
    tick();
    ld_issue = 1'b0; reissue_ok = 1'b0;
    check_eq("t5_ret_a3", 32'(a3), 32'd9);
    check_eq("t5_ret_we3", 32'(we3), 32'd1);
    check_eq("t5_set_wins", pending, 32'h0000_0200);
    alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h20;
    for (int i = 11; i <= 13; i++) begin
      ld_valid = 1'b1; ld_rd = 5'(i); ld_data = 32'(i);
      tick();
    end
    ld_valid = 1'b0;
    check_eq("t5_pre_rst_we3", 32'(we3), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("t5_rst_we3", 32'(we3), 32'd0);
    check_eq("t5_rst_pend", pending, 32'd0);
    check_eq("t5_rst_ready", 32'(ld_ready), 32'd1);
    alu_valid = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t5_no_writes", 32'(we3), 32'd0);
    end
    check_eq("t5_pend_after", pending, 32'd0);

`ifdef WB_BYPASS_EN
    // 6: forwarding of the write landing this cycle
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA5A5A5A5;
    tick();
    alu_valid = 1'b0;
    ra1 = 5'd3; rd1_in = 32'd0; ra2 = 5'd0; rd2_in = 32'h77;
    #1;
    check_eq("t6_fwd1", fwd1, 32'hA5A5A5A5);
    check_eq("t6_fwd2", fwd2, 32'h77);
    tick();
    check_eq("t6_fwd1_idle", fwd1, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
